fpu_add_pipelined: RTL and testbench
====================================

// Module: fpu_add_pipelined
// PURPOSE
//  Parametrised, 3-stage pipelined IEEE-754 add/subtract core (align -> add -> normalize) with valid/ready
//  flow control. Replaces the combinational add stage functions in the FPU datapath and feeds the shared
//  rounding stage with an unrounded result plus guard bits. Adds a subtract op, denormal-correct normalisation
//  and full special-case flags.
// PARAMETERS
//  EXP_WIDTH   8   exponent field width
//  MAN_WIDTH   23  stored mantissa width (hidden bit excluded)
//  GUARD_BITS  3   guard/round/sticky bits carried to rounding; LSB is sticky
// PORTS  (F = 1+EXP_WIDTH+MAN_WIDTH)
//  clk           in   1            clock
//  rst           in   1            synchronous active-high reset
//  in_valid      in   1            operand beat valid
//  in_ready      out  1            core accepts beat this cycle
//  in_a, in_b    in   F            packed IEEE operands {sign,exp,man}
//  in_sub        in   1            1: a-b (b sign inverted at stage 1), 0: a+b
//  in_mode       in   3            rounding mode, passed through untouched
//  out_valid     out  1            result valid
//  out_ready     in   1            downstream accepts result
//  out_sign      out  1            result sign
//  out_exponent  out  EXP_WIDTH    biased result exponent (0 = denormal/zero)
//  out_mantissa  out  MAN_WIDTH+1  significand incl. hidden bit
//  out_guard     out  GUARD_BITS   bits below mantissa, LSB sticky
//  out_nan/out_inf/out_zero out 1  special-result flags
//  out_mode      out  3            rounding mode of this result
// BEHAVIOUR
//  Reset: all stage valid bits 0; out_valid=0; all out_* data 0; in_ready=1 on first cycle after reset.
//  Handshake: beat transfers when valid&&ready. Stage k loads when empty or stage k+1 loads/out drains.
//   in_ready = !s1_valid || s1_advance (combinational from out_ready via chain); no bubbles at full rate.
//   Latency exactly 3 cycles with out_ready=1; throughput 1/cycle; order preserved; no drop/duplication.
//   Output data held stable while out_valid && !out_ready.
//  Stage 1 (align): W = MAN_WIDTH+1+GUARD_BITS. sig = {!denorm, man, GUARD_BITS'0}; eff_exp = exp + denorm.
//   Swap so larger eff_exp is A (ties: keep order). diff clamped to W; B >>= diff with all shifted-out bits
//   ORed into B[0]. Effective sub = sign_a ^ sign_b ^ in_sub.
//  Stage 2 (add): W+1-bit sum or magnitude difference; result sign = sign of larger magnitude;
//   equal magnitudes on effective sub -> exact zero.
//  Stage 3 (normalize): carry -> shift right 1 with sticky, exp+1; exp reaching all-ones -> out_inf=1,
//   mantissa/guard 0. Else left shift by leading zeros, limited to (exp-1); if MSB still 0 -> out_exponent=0.
//  Special cases (priority order): any NaN input, or inf with inf on effective sub -> out_nan=1, sign 0,
//   exponent all-ones, mantissa MSB..MSB-1 = 2'b11 (quiet). Any inf -> out_inf=1, sign of that inf.
//   Exact zero result -> out_zero=1, exponent/mantissa/guard 0; sign = sign_a&sign_b', where b' is the
//   post-in_sub sign, for zero+zero, else 0 unless in_mode==RDN (3'b010) -> 1.
//  Reset mid-operation: all in-flight beats discarded; no out_valid for them after reset release.
// TESTING  (defaults, single precision)
//  0x3F800000 + 0x3F800000 -> sign 0, exp 0x80, mant 0x800000, guard 0, flags 0, 3-cycle latency.
//  0x3F800000 - 0x3F800000 (in_sub=1), mode RNE -> out_zero=1, sign 0; same with mode RDN -> sign 1.
//  0x7F800000 + 0xFF800000 -> out_nan=1; 0x7F800000 + 0x3F800000 -> out_inf=1, sign 0.
//  0x00000001 + 0x00000001 -> exp 0, mant 0x000002; 0x7F7FFFFF + 0x7F7FFFFF -> out_inf=1.
//  0x3F800000 + 0x33800000 (2^-24) -> mant 0x800000, guard 3'b100; 0x3F800000 + 0x00000001 -> guard 3'b001.
//  16 back-to-back beats, out_ready random 50% -> all 16 results in order vs. reference model; rst mid-burst
//   -> out_valid low next cycle, no stale beats.

Source files
------------

// File: rtl/fpu_add_pipelined.sv
// rtl/fpu_add_pipelined.sv - 3-stage pipelined IEEE-754 add/subtract core (align, add, normalize)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake
//   in_a, in_b               packed operands {sign, exp, man}
//   in_sub                   1: a-b, 0: a+b
//   in_mode                  rounding mode, carried alongside the beat
//   out_valid/out_ready      result handshake
//   out_sign/out_exponent    result sign and biased exponent (0 = denormal/zero)
//   out_mantissa             significand including hidden bit
//   out_guard                bits below the mantissa, LSB sticky
//   out_nan/out_inf/out_zero special-result flags
//   out_mode                 rounding mode of this result
module fpu_add_pipelined #(
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23,
  parameter int GUARD_BITS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]    in_a,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]    in_b,
  input  logic                            in_sub,
  input  logic [2:0]                      in_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sign,
  output logic [EXP_WIDTH-1:0]            out_exponent,
  output logic [MAN_WIDTH:0]              out_mantissa,
  output logic [GUARD_BITS-1:0]           out_guard,
  output logic                            out_nan,
  output logic                            out_inf,
  output logic                            out_zero,
  output logic [2:0]                      out_mode
);

  localparam int F   = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int W   = MAN_WIDTH + 1 + GUARD_BITS;
  localparam int LZW = $clog2(W + 1);
  localparam int SW  = (LZW > EXP_WIDTH) ? LZW : EXP_WIDTH;
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
  localparam logic [2:0]           MODE_RDN = 3'b010;

  // ---------------- flow control ----------------
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_en, s2_en, s3_en;

  // A stage loads when it is empty or its content moves on this cycle.
  assign s3_en    = !s3_valid_q || out_ready;
  assign s2_en    = !s2_valid_q || s3_en;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      if (s1_en) s1_valid_q <= in_valid;
      if (s2_en) s2_valid_q <= s1_valid_q;
      if (s3_en) s3_valid_q <= s2_valid_q;
    end
  end

  // ---------------- stage 1: align ----------------
  logic                 sa, sb;
  logic [EXP_WIDTH-1:0] ea, eb, eea, eeb, diff1;
  logic [MAN_WIDTH-1:0] ma, mb;
  logic                 den_a, den_b, nan_a, nan_b, inf_a, inf_b, zro_a, zro_b, swap;
  logic [W-1:0]         sig_a, sig_b, big_sig, sm_sig, sm_shift;
  logic [SW-1:0]        sh1;
  logic                 lost1;

  logic                 s1_sign_a_d, s1_sign_b_d, s1_sub_d, s1_nan_d, s1_inf_d, s1_inf_sign_d, s1_bz_d;
  logic [EXP_WIDTH-1:0] s1_exp_d;
  logic [W-1:0]         s1_sig_a_d, s1_sig_b_d;

  always_comb begin
    sa    = in_a[F-1];
    sb    = in_b[F-1] ^ in_sub;  // b sign after applying the subtract op
    ea    = in_a[F-2:MAN_WIDTH];
    eb    = in_b[F-2:MAN_WIDTH];
    ma    = in_a[MAN_WIDTH-1:0];
    mb    = in_b[MAN_WIDTH-1:0];
    den_a = (ea == '0);
    den_b = (eb == '0);
    nan_a = (ea == EXP_ONES) && (ma != '0);
    nan_b = (eb == EXP_ONES) && (mb != '0);
    inf_a = (ea == EXP_ONES) && (ma == '0);
    inf_b = (eb == EXP_ONES) && (mb == '0);
    zro_a = den_a && (ma == '0);
    zro_b = den_b && (mb == '0);
    sig_a = {!den_a, ma, {GUARD_BITS{1'b0}}};
    sig_b = {!den_b, mb, {GUARD_BITS{1'b0}}};
    // Denormals share the scale of exponent 1.
    eea   = ea + {{(EXP_WIDTH-1){1'b0}}, den_a};
    eeb   = eb + {{(EXP_WIDTH-1){1'b0}}, den_b};
    swap  = (eeb > eea);

    s1_sign_a_d = swap ? sb : sa;
    s1_sign_b_d = swap ? sa : sb;
    s1_exp_d    = swap ? eeb : eea;
    big_sig     = swap ? sig_b : sig_a;
    sm_sig      = swap ? sig_a : sig_b;
    diff1       = swap ? (eeb - eea) : (eea - eeb);
    sh1         = (SW'(diff1) > SW'(W)) ? SW'(W) : SW'(diff1);
    sm_shift    = sm_sig >> sh1;
    // Every bit shifted out collapses into the sticky LSB.
    lost1       = |(sm_sig & ~({W{1'b1}} << sh1));
    s1_sig_a_d  = big_sig;
    s1_sig_b_d  = {sm_shift[W-1:1], sm_shift[0] | lost1};
    s1_sub_d    = sa ^ sb;

    s1_nan_d      = nan_a || nan_b || (inf_a && inf_b && (sa ^ sb));
    s1_inf_d      = inf_a || inf_b;
    s1_inf_sign_d = inf_a ? sa : sb;
    s1_bz_d       = zro_a && zro_b;
  end

  logic                 s1_sign_a_q, s1_sign_b_q, s1_sub_q, s1_nan_q, s1_inf_q, s1_inf_sign_q, s1_bz_q;
  logic [EXP_WIDTH-1:0] s1_exp_q;
  logic [W-1:0]         s1_sig_a_q, s1_sig_b_q;
  logic [2:0]           s1_mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign_a_q <= 1'b0; s1_sign_b_q <= 1'b0; s1_sub_q <= 1'b0;
      s1_nan_q <= 1'b0; s1_inf_q <= 1'b0; s1_inf_sign_q <= 1'b0; s1_bz_q <= 1'b0;
      s1_exp_q <= '0; s1_sig_a_q <= '0; s1_sig_b_q <= '0; s1_mode_q <= '0;
    end else if (s1_en) begin
      s1_sign_a_q <= s1_sign_a_d; s1_sign_b_q <= s1_sign_b_d; s1_sub_q <= s1_sub_d;
      s1_nan_q <= s1_nan_d; s1_inf_q <= s1_inf_d; s1_inf_sign_q <= s1_inf_sign_d; s1_bz_q <= s1_bz_d;
      s1_exp_q <= s1_exp_d; s1_sig_a_q <= s1_sig_a_d; s1_sig_b_q <= s1_sig_b_d; s1_mode_q <= in_mode;
    end
  end

  // ---------------- stage 2: add ----------------
  logic [W:0] s2_sum_d;
  logic       s2_sign_d, s2_zero_d, s2_zsign_d;

  always_comb begin
    if (!s1_sub_q) begin
      s2_sum_d  = {1'b0, s1_sig_a_q} + {1'b0, s1_sig_b_q};
      s2_sign_d = s1_sign_a_q;
    end else if (s1_sig_a_q >= s1_sig_b_q) begin
      s2_sum_d  = {1'b0, s1_sig_a_q} - {1'b0, s1_sig_b_q};
      s2_sign_d = s1_sign_a_q;
    end else begin
      // Same exponent but b has the larger significand.
      s2_sum_d  = {1'b0, s1_sig_b_q} - {1'b0, s1_sig_a_q};
      s2_sign_d = s1_sign_b_q;
    end
    s2_zero_d  = (s2_sum_d == '0);
    s2_zsign_d = s1_bz_q ? (s1_sign_a_q & s1_sign_b_q) : (s1_mode_q == MODE_RDN);
  end

  logic                 s2_sign_q, s2_zero_q, s2_zsign_q, s2_nan_q, s2_inf_q, s2_inf_sign_q;
  logic [EXP_WIDTH-1:0] s2_exp_q;
  logic [W:0]           s2_sum_q;
  logic [2:0]           s2_mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sign_q <= 1'b0; s2_zero_q <= 1'b0; s2_zsign_q <= 1'b0;
      s2_nan_q <= 1'b0; s2_inf_q <= 1'b0; s2_inf_sign_q <= 1'b0;
      s2_exp_q <= '0; s2_sum_q <= '0; s2_mode_q <= '0;
    end else if (s2_en) begin
      s2_sign_q <= s2_sign_d; s2_zero_q <= s2_zero_d; s2_zsign_q <= s2_zsign_d;
      s2_nan_q <= s1_nan_q; s2_inf_q <= s1_inf_q; s2_inf_sign_q <= s1_inf_sign_q;
      s2_exp_q <= s1_exp_q; s2_sum_q <= s2_sum_d; s2_mode_q <= s1_mode_q;
    end
  end

  // ---------------- stage 3: normalize ----------------
  logic [LZW-1:0]       lz;
  logic [SW-1:0]        lz_x, em1_x, sh3;
  logic                 s3_sign_d, s3_nan_d, s3_inf_d, s3_zero_d;
  logic [EXP_WIDTH-1:0] s3_exp_d;
  logic [W-1:0]         s3_sig_d;

  always_comb begin
    lz = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (s2_sum_q[i]) lz = LZW'(W - 1 - i);
    end
    lz_x  = SW'(lz);
    em1_x = SW'(s2_exp_q - 1'b1);
    sh3   = '0;

    s3_sign_d = s2_sign_q;
    s3_nan_d  = 1'b0;
    s3_inf_d  = 1'b0;
    s3_zero_d = 1'b0;

    if (s2_sum_q[W]) begin
      s3_sig_d = {s2_sum_q[W:2], s2_sum_q[1] | s2_sum_q[0]};
      s3_exp_d = s2_exp_q + 1'b1;
      if (s3_exp_d == EXP_ONES) begin
        s3_inf_d = 1'b1;
        s3_sig_d = '0;
      end
    end else begin
      // Shift no further than exponent 1; anything left unnormalized is denormal.
      sh3      = (lz_x < em1_x) ? lz_x : em1_x;
      s3_sig_d = s2_sum_q[W-1:0] << sh3;
      s3_exp_d = s2_exp_q - EXP_WIDTH'(sh3);
      if (!s3_sig_d[W-1]) s3_exp_d = '0;
    end

    if (s2_nan_q) begin
      s3_sign_d = 1'b0;
      s3_exp_d  = EXP_ONES;
      s3_sig_d  = {2'b11, {(W-2){1'b0}}};
      s3_nan_d  = 1'b1;
      s3_inf_d  = 1'b0;
    end else if (s2_inf_q) begin
      s3_sign_d = s2_inf_sign_q;
      s3_exp_d  = EXP_ONES;
      s3_sig_d  = '0;
      s3_inf_d  = 1'b1;
    end else if (s2_zero_q) begin
      s3_sign_d = s2_zsign_q;
      s3_exp_d  = '0;
      s3_sig_d  = '0;
      s3_zero_d = 1'b1;
    end else if (s3_inf_d) begin
      s3_exp_d  = EXP_ONES;
    end
  end

  logic                 s3_sign_q, s3_nan_q, s3_inf_q, s3_zero_q;
  logic [EXP_WIDTH-1:0] s3_exp_q;
  logic [W-1:0]         s3_sig_q;
  logic [2:0]           s3_mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_sign_q <= 1'b0; s3_nan_q <= 1'b0; s3_inf_q <= 1'b0; s3_zero_q <= 1'b0;
      s3_exp_q <= '0; s3_sig_q <= '0; s3_mode_q <= '0;
    end else if (s3_en) begin
      s3_sign_q <= s3_sign_d; s3_nan_q <= s3_nan_d; s3_inf_q <= s3_inf_d; s3_zero_q <= s3_zero_d;
      s3_exp_q <= s3_exp_d; s3_sig_q <= s3_sig_d; s3_mode_q <= s2_mode_q;
    end
  end

  assign out_valid    = s3_valid_q;
  assign out_sign     = s3_sign_q;
  assign out_exponent = s3_exp_q;
  assign out_mantissa = s3_sig_q[W-1:GUARD_BITS];
  assign out_guard    = s3_sig_q[GUARD_BITS-1:0];
  assign out_nan      = s3_nan_q;
  assign out_inf      = s3_inf_q;
  assign out_zero     = s3_zero_q;
  assign out_mode     = s3_mode_q;

endmodule

// File: tb/tb_fpu_add_pipelined.sv
// tb/tb_fpu_add_pipelined.sv - directed-vector bench for fpu_add_pipelined
module tb_fpu_add_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        in_sub;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exponent;
  logic [23:0] out_mantissa;
  logic [2:0]  out_guard;
  logic        out_nan, out_inf, out_zero;
  logic [2:0]  out_mode;

  always #5 clk = ~clk;

  fpu_add_pipelined #(.EXP_WIDTH(8), .MAN_WIDTH(23), .GUARD_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exponent(out_exponent), .out_mantissa(out_mantissa),
    .out_guard(out_guard), .out_nan(out_nan), .out_inf(out_inf), .out_zero(out_zero),
    .out_mode(out_mode)
  );

  // {sign, exp, mant, guard, nan, inf, zero, mode}
  logic [41:0] obs;
  assign obs = {out_sign, out_exponent, out_mantissa, out_guard, out_nan, out_inf, out_zero, out_mode};

  localparam int NV = 17;
  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic        vs [NV];
  logic [2:0]  vm [NV];
  logic [41:0] vexp [NV];

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] mk(input logic s, input logic [7:0] e, input logic [23:0] m,
                                     input logic [2:0] g, input logic n, input logic i,
                                     input logic z, input logic [2:0] md);
    return {s, e, m, g, n, i, z, md};
  endfunction

  task automatic set_vec(input int k);
    in_a = va[k]; in_b = vb[k]; in_sub = vs[k]; in_mode = vm[k];
  endtask

  task automatic add_vec(input int k, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [2:0] md, input logic [41:0] e);
    va[k] = a; vb[k] = b; vs[k] = s; vm[k] = md; vexp[k] = e;
  endtask

  task automatic run_stream(input int first, input int n, input bit rnd, input string tag);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit fire_in;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    set_vec(first);
    out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      fire_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check_val($sformatf("%s_%0d", tag, first + got), 64'(obs), 64'(vexp[first + got]));
        got++;
      end
      if (fire_in) sent++;
      @(posedge clk); #1;
      cyc++;
      in_valid = (sent < n);
      set_vec(first + ((sent < n) ? sent : 0));
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_val({tag, "_count"}, 64'(got), 64'(n));
  endtask

  initial begin
    int   lat;
    int   stray;
    logic [41:0] cap;

    add_vec(0,  32'h3F800000, 32'h3F800000, 0, 3'b000, mk(0, 8'h80, 24'h800000, 3'b000, 0, 0, 0, 3'b000));
    add_vec(1,  32'h3F800000, 32'h3F800000, 1, 3'b000, mk(0, 8'h00, 24'h000000, 3'b000, 0, 0, 1, 3'b000));
    add_vec(2,  32'h3F800000, 32'h3F800000, 1, 3'b010, mk(1, 8'h00, 24'h000000, 3'b000, 0, 0, 1, 3'b010));
    add_vec(3,  32'h7F800000, 32'hFF800000, 0, 3'b000, mk(0, 8'hFF, 24'hC00000, 3'b000, 1, 0, 0, 3'b000));
    add_vec(4,  32'h7F800000, 32'h3F800000, 0, 3'b000, mk(0, 8'hFF, 24'h000000, 3'b000, 0, 1, 0, 3'b000));
    add_vec(5,  32'h00000001, 32'h00000001, 0, 3'b100, mk(0, 8'h00, 24'h000002, 3'b000, 0, 0, 0, 3'b100));
    add_vec(6,  32'h7F7FFFFF, 32'h7F7FFFFF, 0, 3'b000, mk(0, 8'hFF, 24'h000000, 3'b000, 0, 1, 0, 3'b000));
    add_vec(7,  32'h3F800000, 32'h33800000, 0, 3'b000, mk(0, 8'h7F, 24'h800000, 3'b100, 0, 0, 0, 3'b000));
    add_vec(8,  32'h3F800000, 32'h00000001, 0, 3'b000, mk(0, 8'h7F, 24'h800000, 3'b001, 0, 0, 0, 3'b000));
    add_vec(9,  32'h40000000, 32'h3F800000, 1, 3'b001, mk(0, 8'h7F, 24'h800000, 3'b000, 0, 0, 0, 3'b001));
    add_vec(10, 32'h3F800000, 32'h40000000, 1, 3'b000, mk(1, 8'h7F, 24'h800000, 3'b000, 0, 0, 0, 3'b000));
    add_vec(11, 32'hC0400000, 32'h3F800000, 0, 3'b000, mk(1, 8'h80, 24'h800000, 3'b000, 0, 0, 0, 3'b000));
    add_vec(12, 32'h00800000, 32'h00400000, 1, 3'b000, mk(0, 8'h00, 24'h400000, 3'b000, 0, 0, 0, 3'b000));
    add_vec(13, 32'h00400000, 32'h00400000, 0, 3'b000, mk(0, 8'h01, 24'h800000, 3'b000, 0, 0, 0, 3'b000));
    add_vec(14, 32'h7FC00000, 32'h3F800000, 0, 3'b000, mk(0, 8'hFF, 24'hC00000, 3'b000, 1, 0, 0, 3'b000));
    add_vec(15, 32'h3F800000, 32'hBF800000, 0, 3'b010, mk(1, 8'h00, 24'h000000, 3'b000, 0, 0, 1, 3'b010));
    add_vec(16, 32'h80000000, 32'h80000000, 0, 3'b000, mk(1, 8'h00, 24'h000000, 3'b000, 0, 0, 1, 3'b000));

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset_out_valid", 64'(out_valid), 64'd0);
    check_val("reset_in_ready", 64'(in_ready), 64'd1);
    check_val("reset_out_data", 64'(obs), 64'd0);

    // Single beat: result must appear in the third cycle after the one it was offered in.
    @(posedge clk); #1;
    in_valid = 1'b1; set_vec(0); out_ready = 1'b1;
    lat = -1; cap = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid && lat < 0) begin
        lat = c;
        cap = obs;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    check_val("latency", 64'(lat), 64'd3);
    check_val("latency_data", 64'(cap), 64'(vexp[0]));

    for (int k = 0; k < NV; k++) run_stream(k, 1, 1'b0, "vec");

    run_stream(0, 16, 1'b1, "burst");

    // Fill the pipeline while stalled, then reset it.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; set_vec(7);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_val("stall_full_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_mid_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check_val("rst_mid_stale", 64'(stray), 64'd0);

    run_stream(7, 1, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
